// File: rtl/class_score_accumulator.sv
// class_score_accumulator: streaming ten-lane saturating multiply-accumulate feeding the argmax stage
module class_score_accumulator #(
  parameter int NUM_SIZE     = 26,
  parameter int X_SIZE       = 8,
  parameter int W_SIZE       = 8,
  parameter int NUM_FEATURES = 784,
  parameter int CNT_SIZE     = 10
) (
  input  logic                   Clock,
  input  logic                   GlobalReset,
  input  logic                   Start,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [X_SIZE-1:0]      X,
  input  logic [W_SIZE*10-1:0]   W,
  output logic [NUM_SIZE*10-1:0] Num,
  output logic                   Valid,
  output logic                   Busy
);
  localparam int P  = X_SIZE + W_SIZE;
  localparam int SW = (NUM_SIZE > P ? NUM_SIZE : P) + 1;
  localparam logic [SW-1:0] MAX = SW'({NUM_SIZE{1'b1}});
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state;
  logic [NUM_SIZE*10-1:0] acc, nxt;
  logic [CNT_SIZE-1:0] cnt;
  for (genvar k = 0; k < 10; k++) begin : g_lane
    logic [P-1:0] prod;
    logic [SW-1:0] sum;
    assign prod = X * W[W_SIZE*k +: W_SIZE];
    assign sum = SW'(acc[NUM_SIZE*k +: NUM_SIZE]) + SW'(prod);
    assign nxt[NUM_SIZE*k +: NUM_SIZE] = sum > MAX ? {NUM_SIZE{1'b1}} : sum[NUM_SIZE-1:0];
  end
  assign InReady = state == ACCUM;
  assign Valid = state == DONE;
  assign Busy = state != IDLE;
  // Run control, lane accumulation, and publishing of the final sums on the last accepted beat
  always_ff @(posedge Clock or negedge GlobalReset)
    if (!GlobalReset) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      Num <= '0;
    end else
      case (state)
        IDLE: if (Start) begin
          acc <= '0;
          cnt <= '0;
          state <= ACCUM;
        end
        ACCUM: if (InValid) begin
          acc <= nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_SIZE'(NUM_FEATURES - 1)) begin
            Num <= nxt;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_class_score_accumulator.sv
// tb_class_score_accumulator: directed checks of accumulation, gaps, saturation, hold and reset
module tb_class_score_accumulator;
  logic Clock = 0, GlobalReset = 0, Start = 0, InValid = 0;
  logic [7:0] X = '0;
  logic [79:0] W = '0;
  logic InReady0, Valid0, Busy0, InReady1, Valid1, Busy1;
  logic [259:0] Num0, exp0;
  logic [159:0] Num1, exp1;
  logic [79:0] wmul, wsat;
  int checks = 0, errors = 0;

  always #5 Clock = ~Clock;

  class_score_accumulator #(.NUM_SIZE(26), .NUM_FEATURES(4), .CNT_SIZE(10)) u0 (
    .Clock(Clock), .GlobalReset(GlobalReset), .Start(Start), .InValid(InValid), .InReady(InReady0),
    .X(X), .W(W), .Num(Num0), .Valid(Valid0), .Busy(Busy0));
  class_score_accumulator #(.NUM_SIZE(16), .NUM_FEATURES(4), .CNT_SIZE(10)) u1 (
    .Clock(Clock), .GlobalReset(GlobalReset), .Start(Start), .InValid(InValid), .InReady(InReady1),
    .X(X), .W(W), .Num(Num1), .Valid(Valid1), .Busy(Busy1));

  task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic v, input logic r, input logic b);
    chk({tag, " valid"}, 260'({Valid0, Valid1}), 260'({v, v}));
    chk({tag, " inready"}, 260'({InReady0, InReady1}), 260'({r, r}));
    chk({tag, " busy"}, 260'({Busy0, Busy1}), 260'({b, b}));
  endtask

  task automatic chk_num(input string tag);
    chk({tag, " num26"}, Num0, exp0);
    chk({tag, " num16"}, 260'(Num1), 260'(exp1));
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [259:0] n26(input int base, input int step);
    logic [259:0] r;
    for (int k = 0; k < 10; k++) r[26*k +: 26] = 26'(base + step * k);
    return r;
  endfunction

  function automatic logic [159:0] n16(input int base, input int step);
    logic [159:0] r;
    for (int k = 0; k < 10; k++) r[16*k +: 16] = 16'(base + step * k);
    return r;
  endfunction

  task automatic do_run(input logic [79:0] w, input logic [7:0] xf, input int gap, input bit mid_start);
    Start = 1;
    tick;
    Start = 0;
    chk_ctl("run start", 0, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      X = xf != 0 ? xf : 8'(i);
      W = w;
      InValid = 1;
      Start = mid_start && i == 2;
      tick;
      InValid = 0;
      Start = 0;
      X = 8'($urandom);
      W = {16'($urandom), 32'($urandom), 32'($urandom)};
      if (i < 4) chk_ctl("beat", 0, 1, 1);
      else chk_ctl("done", 1, 0, 1);
      if (i == 2) chk_num("held mid-run");
      if (i < 4) repeat (gap) begin
        tick;
        chk_ctl("gap", 0, 1, 1);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 10; k++) wmul[8*k +: 8] = 8'(k);
    wsat = {{9{8'd1}}, 8'd255};
    exp0 = '0;
    exp1 = '0;
    repeat (3) begin
      X = 8'($urandom);
      W = {16'($urandom), 32'($urandom), 32'($urandom)};
      Start = 1'($urandom);
      InValid = 1'($urandom);
      tick;
    end
    chk_num("reset");
    chk_ctl("reset", 0, 0, 0);
    Start = 0;
    InValid = 0;
    GlobalReset = 1;
    repeat (5) begin
      tick;
      chk_ctl("post-reset idle", 0, 0, 0);
    end
    do_run(wmul, 0, 0, 0);
    exp0 = n26(0, 10);
    exp1 = n16(0, 10);
    chk_num("basic");
    tick;
    chk_ctl("basic idle", 0, 0, 0);
    chk_num("basic hold");
    do_run(wmul, 0, 3, 0);
    chk_num("gapped");
    tick;
    do_run(wsat, 8'd255, 0, 0);
    exp0 = n26(1020, 0);
    exp0[25:0] = 26'd260100;
    exp1 = n16(1020, 0);
    exp1[15:0] = 16'hFFFF;
    chk_num("saturate");
    tick;
    do_run(wmul, 0, 0, 0);
    exp0 = n26(0, 10);
    exp1 = n16(0, 10);
    chk_num("prep hold");
    tick;
    do_run(80'd0, 0, 0, 1);
    exp0 = '0;
    exp1 = '0;
    chk_num("zero run");
    tick;
    do_run(wmul, 0, 0, 0);
    exp0 = n26(0, 10);
    exp1 = n16(0, 10);
    chk_num("prep reset");
    tick;
    Start = 1;
    tick;
    Start = 0;
    for (int i = 1; i <= 2; i++) begin
      X = 8'(i);
      W = wmul;
      InValid = 1;
      tick;
    end
    InValid = 0;
    #2 GlobalReset = 0;
    #1;
    exp0 = '0;
    exp1 = '0;
    chk_num("mid-run reset");
    chk_ctl("mid-run reset", 0, 0, 0);
    tick;
    GlobalReset = 1;
    tick;
    chk_ctl("after reset idle", 0, 0, 0);
    do_run(wmul, 0, 0, 0);
    exp0 = n26(0, 10);
    exp1 = n16(0, 10);
    chk_num("fresh run");
    tick;
    chk_ctl("final idle", 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
